serial_word_receiver: RTL
=========================

SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

Interface
REQ-001 The module SHALL take parameter WORD_LENGTH, default 8, meaning the number of bits per received word (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port serialInput, input, 1 bit: serial data, MSB first, as produced by the team's left-shifting transmitter.
REQ-005 The module SHALL have port shift, input, 1 bit: bit-qualify; serialInput is sampled only on edges where shift=1.
REQ-006 The module SHALL have port start, input, 1 bit: synchronous frame start/restart request.
REQ-007 The module SHALL have port parallelOutput, output, WORD_LENGTH bits: last completed word, registered.
REQ-008 The module SHALL have port dataValid, output, 1 bit: one-cycle pulse marking a new word on parallelOutput.
REQ-009 The module SHALL have port busy, output, 1 bit: high while a frame is being received.

Function
REQ-010 The module SHALL implement a three-state FSM: IDLE, RECEIVE and DONE.
REQ-011 In IDLE, start=1 SHALL move to RECEIVE and clear the internal shift register and bit counter; shift and serialInput SHALL be ignored in IDLE.
REQ-012 In RECEIVE, on each edge with shift=1, the shift register SHALL load {shiftReg[WORD_LENGTH-2:0], serialInput} and the bit counter SHALL increment.
REQ-013 In RECEIVE, shift=0 SHALL hold the shift register and counter unchanged; gaps of any length SHALL be tolerated.
REQ-014 The bit counter SHALL be clog2(WORD_LENGTH) bits wide and SHALL never exceed WORD_LENGTH-1.
REQ-015 On the edge in RECEIVE where shift=1 and the counter equals WORD_LENGTH-1: parallelOutput SHALL load {shiftReg[WORD_LENGTH-2:0], serialInput}, the counter SHALL clear, and the FSM SHALL go to DONE.
REQ-016 dataValid SHALL be high only in DONE, for exactly one clock, i.e. in the cycle after the edge that captured the last bit.
REQ-017 From DONE, the FSM SHALL go to RECEIVE if start=1 (back-to-back frame, counter cleared), otherwise to IDLE.
REQ-018 A shift=1 in DONE SHALL be ignored; a new frame's first bit is sampled no earlier than the first RECEIVE cycle.
REQ-019 start=1 in RECEIVE SHALL abort the current frame: counter and shift register cleared, the FSM stays in RECEIVE, no dataValid, parallelOutput unchanged; a simultaneous shift=1 on that edge SHALL be discarded.
REQ-020 busy SHALL be 1 in RECEIVE and 0 in IDLE and DONE.
REQ-021 parallelOutput SHALL change only on the edge specified in REQ-015 and SHALL hold its value otherwise, including through aborts.

Reset
REQ-022 reset=0 SHALL immediately and asynchronously force IDLE, counter=0, shift register=0, parallelOutput=0, dataValid=0 and busy=0, including mid-frame.
REQ-023 After reset deasserts, no frame SHALL begin until start=1 is sampled; bits received before reset SHALL be lost.

Verification
REQ-024 Basic word: W=8, start pulse, then 8 consecutive cycles with shift=1 carrying 1,0,1,0,1,0,1,0 -> parallelOutput=8'hAA (170), a single dataValid pulse one cycle after the 8th bit, busy high for 8 cycles.
REQ-025 Gapped shift: bits 1,1,0,0,0,0,1,1 with shift=0 for 3 cycles after bits 2 and 5 -> parallelOutput=8'hC3, exactly one dataValid pulse, busy held high through the gaps.
REQ-026 Abort: 5 bits of 8'hFF, then start=1 with shift=1, then 8 bits of 8'h0F -> a single dataValid pulse, parallelOutput=8'h0F, and the previous value held until then.
REQ-027 Reset mid-frame: 4 bits received, reset=0 for 1 cycle -> all outputs 0 asynchronously; 8 bits with shift=1 without start -> no dataValid and parallelOutput=0.
REQ-028 Back-to-back: frame 8'h55, start=1 during the DONE cycle, then frame 8'h3C -> two dataValid pulses one frame apart, parallelOutput=8'h55 then 8'h3C.
REQ-029 Idle noise: shift toggling with random serialInput while in IDLE -> busy=0, dataValid=0, parallelOutput unchanged.

Source files
------------

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver.
// Collects WORD_LENGTH bits MSB-first, qualified by shift, after a start request.
// The completed word is presented on parallelOutput with a one-cycle dataValid pulse.
module serial_word_receiver #(
    parameter int unsigned WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   serialInput,
    input  logic                   shift,
    input  logic                   start,
    output logic [WORD_LENGTH-1:0] parallelOutput,
    output logic                   dataValid,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(WORD_LENGTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReceive,
        StDone
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [WORD_LENGTH-1:0] r_shreg;
    logic [WORD_LENGTH-1:0] r_par;
    logic                   r_valid;
    logic                   r_busy;

    logic [WORD_LENGTH-1:0] w_next_word;
    logic                   w_last_bit;

    // Shift register contents after accepting the current serial bit.
    always_comb begin
        w_next_word = {r_shreg[WORD_LENGTH-2:0], serialInput};
        w_last_bit  = (r_cnt == LAST_BIT);
    end

    // Frame FSM with registered outputs; busy mirrors the RECEIVE state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_par   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state <= StReceive;
                        r_cnt   <= '0;
                        r_shreg <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StReceive: begin
                    if (start) begin
                        // Abort: restart the frame, any bit on this edge is dropped.
                        r_cnt   <= '0;
                        r_shreg <= '0;
                    end else if (shift) begin
                        r_shreg <= w_next_word;
                        if (w_last_bit) begin
                            r_par   <= w_next_word;
                            r_cnt   <= '0;
                            r_state <= StDone;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                StDone: begin
                    // shift is ignored here; the next frame samples from RECEIVE.
                    if (start) begin
                        r_state <= StReceive;
                        r_cnt   <= '0;
                        r_shreg <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign parallelOutput = r_par;
    assign dataValid      = r_valid;
    assign busy           = r_busy;

endmodule
